// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bus: two requester ports plus the single memory port.
// The slave modport is the arbiter side and the master modport is the requester/memory side.
interface mem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 6
) ();
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  ack0;
  logic                  ack1;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, ack0, ack1, rdata, busy, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, ack0, ack1, rdata, busy, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of one synchronous-read memory port.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, READ_WAIT, RESP} state_t;

  state_t                state;
  logic                  win_q;
  logic                  wr_q;
  logic                  gnt0_q;
  logic                  gnt1_q;
  logic                  ack0_q;
  logic                  ack1_q;
  logic                  busy_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  pick_c;

`ifdef MEM_ARB_RR_EN
  logic                  last_q;

  // On a tie the requester not served last wins.
  always_comb begin
    pick_c = ~bus.req0;
    if (bus.req0 && bus.req1) pick_c = ~last_q;
  end
`else
  always_comb begin
    pick_c = ~bus.req0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      win_q       <= 1'b0;
      wr_q        <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      busy_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
`ifdef MEM_ARB_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      mem_we_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            win_q       <= pick_c;
            wr_q        <= pick_c ? bus.we1 : bus.we0;
            mem_we_q    <= pick_c ? bus.we1 : bus.we0;
            mem_addr_q  <= pick_c ? bus.addr1 : bus.addr0;
            mem_wdata_q <= pick_c ? bus.wdata1 : bus.wdata0;
            gnt0_q      <= ~pick_c;
            gnt1_q      <= pick_c;
            busy_q      <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef MEM_ARB_RR_EN
          last_q <= win_q;
`endif
          // Writes complete here; reads wait one cycle for the memory's registered data.
          if (wr_q) begin
            ack0_q <= ~win_q;
            ack1_q <= win_q;
            state  <= RESP;
          end else begin
            state  <= READ_WAIT;
          end
        end
        READ_WAIT: begin
          rdata_q <= bus.mem_rdata;
          ack0_q  <= ~win_q;
          ack1_q  <= win_q;
          state   <= RESP;
        end
        RESP: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.busy      = busy_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata     = rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of the memory data word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, width of the memory address.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req0/req1  input  1  access request from requester 0 (CPU) and requester 1 (loader/debug).
REQ-006 SHALL have ports we0/we1  input  1  1 = write, 0 = read, for the matching requester.
REQ-007 SHALL have ports addr0/addr1  input  ADDR_WIDTH  access address per requester.
REQ-008 SHALL have ports wdata0/wdata1  input  DATA_WIDTH  write data per requester.
REQ-009 SHALL have ports gnt0/gnt1  output  1  one-cycle pulse: request accepted.
REQ-010 SHALL have ports ack0/ack1  output  1  one-cycle pulse: access complete.
REQ-011 SHALL have port rdata  output  DATA_WIDTH  last read word; valid while ack is high, held until the next read capture.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have ports mem_we  output  1, mem_addr  output  ADDR_WIDTH, mem_wdata  output  DATA_WIDTH, and mem_rdata  input  DATA_WIDTH, the single shared memory port (synchronous read, data valid one cycle after address).

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, READ_WAIT and RESP.
REQ-015 IDLE: SHALL stay in IDLE when req0 = req1 = 0; otherwise it SHALL select a winner, latch the winner's we/addr/wdata, and move to ISSUE.
REQ-016 ISSUE: SHALL drive mem_addr/mem_wdata from the latched values, drive mem_we = latched we, and assert gnt of the winner; it SHALL go to READ_WAIT for a read and to RESP for a write.
REQ-017 READ_WAIT: SHALL keep mem_we = 0 and mem_addr stable, and SHALL capture mem_rdata into rdata at the end of the cycle; next state RESP.
REQ-018 RESP: SHALL pulse the winner's ack for exactly one cycle; next state IDLE.
REQ-019 Latency: for a request sampled in IDLE at edge N, gnt is high in cycle N+1; write ack is high in cycle N+2; read ack is high in cycle N+3.
REQ-020 mem_we SHALL be high only in ISSUE for a write, and only for one cycle per write.
REQ-021 A requester SHALL hold req/we/addr/wdata stable until its gnt; inputs are ignored outside IDLE.
REQ-022 The losing requester's request SHALL remain pending without loss and be served from the next IDLE.
REQ-023 A request asserted during the ack cycle SHALL be sampled in the following IDLE cycle; no back-to-back bypass of IDLE.
REQ-024 At most one gnt and at most one ack SHALL be high in any cycle; gnt and ack never target a requester that was not the latched winner.
REQ-025 Addresses SHALL be passed unmodified; there is no wrap or range check.

Reset
REQ-026 While rst = 1: state = IDLE; gnt0, gnt1, ack0, ack1, mem_we and busy = 0; mem_addr, mem_wdata and rdata = 0; round-robin pointer = "last served 1".
REQ-027 Reset asserted mid-access SHALL abort it immediately (mem_we falls asynchronously) and no ack SHALL be issued for the aborted access.

Configuration
REQ-028 With MEM_ARB_RR_EN defined: arbitration SHALL be round-robin; on a simultaneous req0 and req1, the requester not served last wins; the pointer updates in ISSUE.
REQ-029 Without MEM_ARB_RR_EN: arbitration SHALL be fixed priority, requester 0 always wins a tie, and no pointer register exists.

Verification
REQ-030 Single read: req0 = 1, we0 = 0, addr0 = 6'd8, memory[8] = 16'hA5A5 -> gnt0 in cycle N+1; ack0 in N+3 with rdata = 16'hA5A5; mem_we never high.
REQ-031 Single write: req1 = 1, we1 = 1, addr1 = 6'd63, wdata1 = 16'h1234 -> mem_we high for one cycle with mem_addr = 63 and mem_wdata = 16'h1234; ack1 in N+2; a subsequent read of 63 returns 16'h1234.
REQ-032 Contention: req0 and req1 held high for 4 accesses -> with MEM_ARB_RR_EN the grant order is 0,1,0,1; without it the grant order is 0,0,0,0 while req0 stays high.
REQ-033 Pending request: req1 asserted during requester 0's READ_WAIT -> no gnt1 until requester 0's ack; gnt1 two cycles after ack0.
REQ-034 Reset mid-read: rst pulsed in READ_WAIT -> busy = 0, no ack0, rdata = 0; the next request completes normally.
REQ-035 Back-to-back: req0 held continuously for writes to addresses 0..3 -> four mem_we pulses, each separated by at least one IDLE cycle, with four ack0 pulses in address order.
